// File: rtl/spu_fetch_pkg.sv
// Shared types and sizing for the SPU instruction line fill path.
package spu_fetch_pkg;

  typedef logic [0:31] instr_t;

  localparam int unsigned LINE_WORDS = 256;
  localparam int unsigned BEAT_WORDS = 4;
  localparam int unsigned BEATS      = LINE_WORDS / BEAT_WORDS;
  localparam int unsigned BEAT_W     = $clog2(BEATS);
  localparam int unsigned SUB_W      = $clog2(BEAT_WORDS);
  localparam int unsigned IDX_W      = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_REQ  = 2'd1,
    FILL_WAIT = 2'd2,
    FILL_DONE = 2'd3
  } fill_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ins_line_fill_if.sv
// Local-store read port bundle between the line fill engine and the LS arbiter.
interface ins_line_fill_if #(
  parameter int unsigned LS_ADDR_W = 14
);
  import spu_fetch_pkg::*;

  logic                        ls_req;
  logic [LS_ADDR_W-1:0]        ls_addr;
  logic                        ls_gnt;
  logic                        ls_rvalid;
  logic [0:32*BEAT_WORDS-1]    ls_rdata;

  modport master (output ls_req, output ls_addr, input ls_gnt, input ls_rvalid, input ls_rdata);
  modport slave  (input ls_req, input ls_addr, output ls_gnt, output ls_rvalid, output ls_rdata);
endinterface

// File: rtl/ins_line_buf.sv
// Instruction line storage: cleared by reset, written one LS beat at a time.
module ins_line_buf
  import spu_fetch_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [BEAT_W-1:0]        beat_idx,
  input  logic [0:32*BEAT_WORDS-1] wdata,
  output instr_t                   mem [0:LINE_WORDS-1]
);

  // Beat write: lowest-addressed instruction sits in the leftmost 32 bits of wdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        mem[IDX_W'(k)] <= 32'h0;
      end
    end else if (we) begin
      for (int i = 0; i < BEAT_WORDS; i++) begin
        mem[{beat_idx, SUB_W'(i)}] <= wdata[32*i +: 32];
      end
    end
  end

endmodule

// File: rtl/ins_line_fill.sv
// Fills the fetch line buffer from local store, one quadword beat per request.
// Optional LINE_FILL_STATS_EN adds fill_count / wait_cycles statistics outputs.
module ins_line_fill
  import spu_fetch_pkg::*;
#(
  parameter int unsigned LS_ADDR_W = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_enable,
  input  logic [LS_ADDR_W-1:0] fill_base,
  ins_line_fill_if.master      ls,
  output instr_t               ins_cache [0:LINE_WORDS-1],
  output logic                 line_valid,
  output logic                 busy
`ifdef LINE_FILL_STATS_EN
  ,
  output logic [15:0]          fill_count,
  output logic [31:0]          wait_cycles
`endif
);

  fill_state_t          state_r, state_nxt_s;
  logic [LS_ADDR_W-1:0] base_r, base_nxt_s, pend_base_r, pend_base_nxt_s, ls_addr_r, ls_addr_nxt_s;
  logic [BEAT_W-1:0]    beat_r, beat_nxt_s;
  logic                 pend_r, pend_nxt_s, line_valid_r, line_valid_nxt_s;
  logic                 ls_req_r, busy_r, we_s;

  // Next-state, beat/address and pending-request decisions.
  always_comb begin
    state_nxt_s      = state_r;
    base_nxt_s       = base_r;
    beat_nxt_s       = beat_r;
    pend_nxt_s       = pend_r;
    pend_base_nxt_s  = pend_base_r;
    line_valid_nxt_s = line_valid_r;
    we_s             = 1'b0;
    case (state_r)
      FILL_IDLE: begin
        if (read_enable) begin
          base_nxt_s       = fill_base;
          beat_nxt_s       = '0;
          pend_nxt_s       = 1'b0;
          line_valid_nxt_s = 1'b0;
          state_nxt_s      = FILL_REQ;
        end else if (pend_r) begin
          base_nxt_s       = pend_base_r;
          beat_nxt_s       = '0;
          pend_nxt_s       = 1'b0;
          line_valid_nxt_s = 1'b0;
          state_nxt_s      = FILL_REQ;
        end else begin
          state_nxt_s      = FILL_IDLE;
        end
      end
      FILL_REQ: begin
        if (read_enable) begin
          pend_nxt_s      = 1'b1;
          pend_base_nxt_s = fill_base;
        end else begin
          pend_nxt_s      = pend_r;
        end
        // A follow-on fill started from DONE drops line_valid on its first beat.
        if (beat_r == '0) begin
          line_valid_nxt_s = 1'b0;
        end else begin
          line_valid_nxt_s = line_valid_r;
        end
        if (ls.ls_gnt) begin
          state_nxt_s = FILL_WAIT;
        end else begin
          state_nxt_s = FILL_REQ;
        end
      end
      FILL_WAIT: begin
        if (read_enable) begin
          pend_nxt_s      = 1'b1;
          pend_base_nxt_s = fill_base;
        end else begin
          pend_nxt_s      = pend_r;
        end
        if (ls.ls_rvalid) begin
          we_s = 1'b1;
          if (beat_r == BEAT_W'(BEATS - 1)) begin
            state_nxt_s = FILL_DONE;
          end else begin
            beat_nxt_s  = beat_r + BEAT_W'(1);
            state_nxt_s = FILL_REQ;
          end
        end else begin
          state_nxt_s = FILL_WAIT;
        end
      end
      FILL_DONE: begin
        line_valid_nxt_s = 1'b1;
        if (pend_r) begin
          base_nxt_s  = pend_base_r;
          beat_nxt_s  = '0;
          pend_nxt_s  = 1'b0;
          state_nxt_s = FILL_REQ;
        end else begin
          state_nxt_s = FILL_IDLE;
        end
      end
      default: begin
        state_nxt_s = FILL_IDLE;
      end
    endcase
    ls_addr_nxt_s = base_nxt_s + LS_ADDR_W'(beat_nxt_s);
  end

  // Fill state and registered outputs; reset aborts any fill in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= FILL_IDLE;
      base_r       <= '0;
      beat_r       <= '0;
      ls_req_r     <= 1'b0;
      ls_addr_r    <= '0;
      line_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      base_r       <= base_nxt_s;
      beat_r       <= beat_nxt_s;
      ls_req_r     <= (state_nxt_s == FILL_REQ);
      ls_addr_r    <= ls_addr_nxt_s;
      line_valid_r <= line_valid_nxt_s;
      busy_r       <= (state_nxt_s != FILL_IDLE);
    end
  end

  // Queued request survives reset so fetch does not have to re-issue it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_r      <= pend_nxt_s;
      pend_base_r <= pend_base_nxt_s;
    end
  end

  ins_line_buf u_buf (
    .clk      (clk),
    .reset    (reset),
    .we       (we_s),
    .beat_idx (beat_r),
    .wdata    (ls.ls_rdata),
    .mem      (ins_cache)
  );

  assign ls.ls_req   = ls_req_r;
  assign ls.ls_addr  = ls_addr_r;
  assign line_valid  = line_valid_r;
  assign busy        = busy_r;

`ifdef LINE_FILL_STATS_EN
  logic [15:0] fill_count_r;
  logic [31:0] wait_cycles_r;

  // Completed fills and stalled REQ/WAIT cycles, both saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_count_r  <= 16'd0;
      wait_cycles_r <= 32'd0;
    end else begin
      if (state_r == FILL_DONE) begin
        fill_count_r <= sat_inc16(fill_count_r);
      end
      if (((state_r == FILL_REQ) && !ls.ls_gnt) || ((state_r == FILL_WAIT) && !ls.ls_rvalid)) begin
        wait_cycles_r <= sat_inc32(wait_cycles_r);
      end
    end
  end

  assign fill_count  = fill_count_r;
  assign wait_cycles = wait_cycles_r;
`endif

endmodule

// File: tb/tb_ins_line_fill.sv
// Self-checking bench for ins_line_fill: randomized LS responder plus line content model.
module tb_ins_line_fill;
  import spu_fetch_pkg::*;

  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          read_enable = 1'b0;
  logic [AW-1:0] fill_base = '0;
  instr_t        ins_cache [0:LINE_WORDS-1];
  logic          line_valid, busy;
`ifdef LINE_FILL_STATS_EN
  logic [15:0]   fill_count;
  logic [31:0]   wait_cycles;
`endif

  ins_line_fill_if #(.LS_ADDR_W(AW)) lsif ();

  ins_line_fill #(.LS_ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .read_enable (read_enable),
    .fill_base   (fill_base),
    .ls          (lsif),
    .ins_cache   (ins_cache),
    .line_valid  (line_valid),
    .busy        (busy)
`ifdef LINE_FILL_STATS_EN
    ,
    .fill_count  (fill_count),
    .wait_cycles (wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // LS responder knobs and bookkeeping
  int            gmax = 0, rmax = 0, rfix = 0;
  logic [7:0]    tag = 8'h00;
  bit            rsp_pend = 1'b0, req_wait = 1'b0;
  int            g_cnt = -1, r_cnt = 0, rv_done = 0, viol = 0;
  logic [AW-1:0] rsp_addr = '0;
  logic [AW-1:0] addr_q [$];
  instr_t        exp_c [0:LINE_WORDS-1];

  function automatic logic [31:0] pat(input logic [7:0] t, input logic [AW-1:0] a, input int i);
    logic [7:0] ii;
    ii = 8'(i);
    return {t, ii, 2'b00, a};
  endfunction

  task automatic model_fill(input logic [AW-1:0] b, input logic [7:0] t);
    for (int k = 0; k < LINE_WORDS; k++) exp_c[k] = pat(t, AW'(b + k / 4), k % 4);
  endtask

  task automatic model_clear();
    for (int k = 0; k < LINE_WORDS; k++) exp_c[k] = 32'h0;
  endtask

  function automatic int cache_diff();
    int n;
    n = 0;
    for (int k = 0; k < LINE_WORDS; k++) if (ins_cache[k] !== exp_c[k]) n++;
    return n;
  endfunction

  task automatic pulse_req(input logic [AW-1:0] b);
    @(negedge clk);
    read_enable = 1'b1;
    fill_base   = b;
    @(negedge clk);
    read_enable = 1'b0;
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < lim; n++) begin
      if (!busy && line_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // LS arbiter model: random grant delay, random read latency, address-tagged data
  initial begin
    lsif.ls_gnt = 1'b0;
    lsif.ls_rvalid = 1'b0;
    lsif.ls_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (lsif.ls_rvalid) rv_done++;
      if (req_wait && !lsif.ls_req && !reset) viol++;
      lsif.ls_gnt = 1'b0;
      lsif.ls_rvalid = 1'b0;
      req_wait = 1'b0;
      if (rsp_pend) begin
        if (r_cnt == 0) begin
          lsif.ls_rvalid = 1'b1;
          for (int i = 0; i < BEAT_WORDS; i++) lsif.ls_rdata[32*i +: 32] = pat(tag, rsp_addr, i);
          rsp_pend = 1'b0;
        end else begin
          r_cnt--;
        end
      end else if (lsif.ls_req) begin
        if (g_cnt < 0) g_cnt = $urandom_range(gmax, 0);
        if (g_cnt == 0) begin
          lsif.ls_gnt = 1'b1;
          addr_q.push_back(lsif.ls_addr);
          rsp_addr = lsif.ls_addr;
          rsp_pend = 1'b1;
          r_cnt = (rfix >= 0) ? rfix : $urandom_range(rmax, 0);
          g_cnt = -1;
        end else begin
          g_cnt--;
          req_wait = 1'b1;
        end
      end
    end
  end

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
    total++; if (lsif.ls_req !== 1'b0) begin bad++; $display("FAIL reset_ls_req: got %b want 0", lsif.ls_req); end
    total++; if (lsif.ls_addr !== 14'h0) begin bad++; $display("FAIL reset_ls_addr: got %h want 0", lsif.ls_addr); end
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL reset_line_valid: got %b want 0", line_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n = cache_diff();
    total++; if (n !== 0) begin bad++; $display("FAIL reset_cache: %0d entries nonzero, want 0", n); end
  endtask

  task automatic test_basic();
    int n, m;
    tag = 8'h11; gmax = 0; rmax = 0; rfix = 0;
    addr_q.delete();
    pulse_req(14'h0100);
    total++; if (lsif.ls_req !== 1'b1) begin bad++; $display("FAIL basic_req_latency: ls_req %b want 1", lsif.ls_req); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    n = 1;
    while (!line_valid && n < 400) begin @(negedge clk); n++; end
    total++; if (n !== 130) begin bad++; $display("FAIL basic_valid_latency: got %0d cycles want 130", n); end
    total++; if (addr_q.size() !== 64) begin bad++; $display("FAIL basic_beats: got %0d want 64", addr_q.size()); end
    m = 0;
    for (int j = 0; j < addr_q.size(); j++) if (addr_q[j] !== AW'(14'h0100 + j)) m++;
    total++; if (m !== 0) begin bad++; $display("FAIL basic_addr_seq: %0d addresses wrong, want 0", m); end
    model_fill(14'h0100, tag);
    n = cache_diff();
    total++; if (n !== 0) begin bad++; $display("FAIL basic_contents: %0d entries differ, want 0", n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle: busy %b want 0", busy); end
  endtask

  task automatic test_random_delays();
    instr_t        old_c [0:LINE_WORDS-1];
    logic [AW-1:0] b;
    int            r0, n, lim;
    bit            ok;
    gmax = 5; rmax = 5; rfix = -1;
    for (int it = 0; it < 3; it++) begin
      tag = 8'h20 + 8'(it);
      b = AW'($urandom_range(16383, 0));
      old_c = exp_c;
      model_fill(b, tag);
      r0 = rv_done;
      pulse_req(b);
      lim = 0;
      while ((rv_done - r0) < 10 && lim < 800) begin @(negedge clk); lim++; end
      n = 0;
      for (int k = 0; k < LINE_WORDS; k++)
        if (ins_cache[k] !== ((k < 40) ? exp_c[k] : old_c[k])) n++;
      total++; if (n !== 0 || lim >= 800) begin bad++; $display("FAIL rand_partial: %0d entries wrong after 10 beats (timeout=%0d), want 0", n, lim >= 800); end
      wait_idle(3000, ok);
      total++; if (!ok) begin bad++; $display("FAIL rand_timeout: busy %b line_valid %b, want 0/1", busy, line_valid); end
      n = cache_diff();
      total++; if (n !== 0) begin bad++; $display("FAIL rand_contents: %0d entries differ, want 0", n); end
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL rand_req_drop: %0d early drops, want 0", viol); end
  endtask

  task automatic test_back_to_back();
    int n, m, lim;
    tag = 8'h30; gmax = 1; rmax = 1; rfix = -1;
    addr_q.delete();
    pulse_req(14'h0400);
    repeat (15) @(negedge clk);
    pulse_req(14'h0200);
    repeat (30) @(negedge clk);
    pulse_req(14'h0300);
    lim = 0;
    while (!(addr_q.size() >= 128 && !busy) && lim < 5000) begin @(negedge clk); lim++; end
    repeat (10) @(negedge clk);
    total++; if (addr_q.size() !== 128) begin bad++; $display("FAIL b2b_beats: got %0d want 128", addr_q.size()); end
    m = 0;
    for (int j = 64; j < addr_q.size(); j++) if (addr_q[j] !== AW'(14'h0300 + j - 64)) m++;
    total++; if (m !== 0) begin bad++; $display("FAIL b2b_second_base: %0d addresses wrong, want 0", m); end
    model_fill(14'h0300, tag);
    n = cache_diff();
    total++; if (n !== 0) begin bad++; $display("FAIL b2b_contents: %0d entries differ, want 0", n); end
    total++; if (line_valid !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_final: line_valid %b busy %b want 1/0", line_valid, busy); end
  endtask

  task automatic test_wrap();
    int n, m;
    bit ok;
    tag = 8'h44; gmax = 2; rmax = 2; rfix = -1;
    addr_q.delete();
    pulse_req(14'h3FF0);
    wait_idle(3000, ok);
    total++; if (!ok || addr_q.size() !== 64) begin bad++; $display("FAIL wrap_done: ok %b beats %0d want 1/64", ok, addr_q.size()); end
    m = 0;
    for (int j = 0; j < addr_q.size(); j++) if (addr_q[j] !== AW'(14'h3FF0 + j)) m++;
    total++; if (m !== 0) begin bad++; $display("FAIL wrap_addr_seq: %0d addresses wrong, want 0", m); end
    model_fill(14'h3FF0, tag);
    n = cache_diff();
    total++; if (n !== 0) begin bad++; $display("FAIL wrap_contents: %0d entries differ, want 0", n); end
  endtask

  task automatic test_reset_abort();
    int r0, n, lim;
    tag = 8'h55; gmax = 0; rmax = 0; rfix = 3;
    r0 = rv_done;
    pulse_req(AW'($urandom_range(16383, 0)));
    lim = 0;
    while (!((rv_done - r0) >= 20 && rsp_pend) && lim < 800) begin @(negedge clk); lim++; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    total++; if (lsif.ls_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_state: ls_req %b busy %b want 0/0", lsif.ls_req, busy); end
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL abort_line_valid: got %b want 0", line_valid); end
    n = cache_diff();
    total++; if (n !== 0) begin bad++; $display("FAIL abort_cache: %0d entries nonzero, want 0", n); end
    repeat (8) @(negedge clk);
    n = cache_diff();
    total++; if (n !== 0 || busy !== 1'b0) begin bad++; $display("FAIL abort_late_rvalid: %0d entries written, busy %b, want 0/0", n, busy); end
    rfix = 0;
  endtask

`ifdef LINE_FILL_STATS_EN
  task automatic test_stats();
    bit ok;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++; if (fill_count !== 16'd0 || wait_cycles !== 32'd0) begin bad++; $display("FAIL stats_reset: %0d/%0d want 0/0", fill_count, wait_cycles); end
    tag = 8'h66; gmax = 0; rfix = 2;
    for (int f = 0; f < 3; f++) begin
      pulse_req(AW'($urandom_range(16383, 0)));
      wait_idle(3000, ok);
    end
    total++; if (fill_count !== 16'd3) begin bad++; $display("FAIL stats_fill_count: got %0d want 3", fill_count); end
    total++; if (wait_cycles !== 32'd384) begin bad++; $display("FAIL stats_wait_cycles: got %0d want 384", wait_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_random_delays();
    test_back_to_back();
    test_wrap();
    test_reset_abort();
`ifdef LINE_FILL_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
